// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   - Default address width and sequential step used by pc_ctrl and pc_ras.
//   - Next-PC select encoding used by the priority selector in pc_ctrl.
package pc_pkg;

  localparam int AW_DEF   = 10;
  localparam int STEP_DEF = 1;

  // Source of the address loaded into the PC at the next edge.
  // A call shares SEL_JMP with jmp; the push is a separate strobe.
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,  // pc + STEP
    SEL_BR  = 2'd1,  // pc + STEP + br_off
    SEL_JMP = 2'd2,  // jmp_tgt (jump or call)
    SEL_RET = 2'd3   // popped return address, or reset vector on underflow
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO of DEPTH entries.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   push, pop   push din / pop top; pop wins if both are set
//   din         address to push
//   dout        current top of stack (combinational read of the register file)
//   empty/full  registered occupancy flags
//   ovf/unf     registered one-cycle pulses: push while full / pop while empty
// A push while full overwrites the oldest entry: the write pointer simply
// advances around the ring and the count saturates at DEPTH.
module pc_ras
  import pc_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, wptr_n;   // next free slot; top is wptr-1
  logic [CW-1:0] count, count_n;
  logic          ovf_n, unf_n;
  logic          is_full, is_empty;

  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);

  always_comb begin
    wptr_n  = wptr;
    count_n = count;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    if (pop) begin
      if (is_empty) begin
        unf_n = 1'b1;
      end else begin
        wptr_n  = wptr - PW'(1);
        count_n = count - CW'(1);
      end
    end else if (push) begin
      wptr_n = wptr + PW'(1);
      if (is_full) begin
        ovf_n = 1'b1;
      end else begin
        count_n = count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      wptr  <= wptr_n;
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == CW'(DEPTH));
      ovf   <= ovf_n;
      unf   <= unf_n;
    end
  end

  // Storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      mem[wptr] <= din;
    end
  end

  assign dout = mem[wptr - PW'(1)];

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter unit for the MIPS datapath.
// Holds the fetch address and selects the next PC with priority
// ret > call > jmp > br_taken > sequential; lower-priority requests in the
// same cycle are dropped. stall freezes the PC and blocks all RAS activity.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   stall          hold pc, ignore all control inputs
//   br_taken       relative branch to pc + STEP + br_off (signed offset)
//   jmp, call      absolute jump to jmp_tgt; call also pushes pc + STEP
//   ret            pop RAS and load the popped address (RESET_VEC if empty)
//   pc             registered fetch address
//   pc_next        address loaded at the next edge
//   ras_empty/full RAS occupancy flags
//   ras_ovf/unf    one-cycle pulses after a push-while-full / pop-while-empty
// All address arithmetic wraps modulo 2^AW without any flag.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_off,
  input  logic          jmp,
  input  logic          call,
  input  logic [AW-1:0] jmp_tgt,
  input  logic          ret,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_next,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_ovf,
  output logic          ras_unf
);

  localparam logic [AW-1:0] STEP_V = AW'(STEP);
  localparam logic [AW-1:0] RST_V  = AW'(RESET_VEC);

  pc_sel_e       sel;
  logic          ras_push, ras_pop;
  logic [AW-1:0] ras_top;
  logic [AW-1:0] pc_seq, pc_br;

  // The call return address is the same sequential successor.
  assign pc_seq = pc + STEP_V;
  assign pc_br  = pc_seq + br_off;

  always_comb begin
    sel      = SEL_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!stall) begin
      if (ret) begin
        sel     = SEL_RET;
        ras_pop = 1'b1;
      end else if (call) begin
        sel      = SEL_JMP;
        ras_push = 1'b1;
      end else if (jmp) begin
        sel = SEL_JMP;
      end else if (br_taken) begin
        sel = SEL_BR;
      end
    end
  end

  always_comb begin
    pc_next = pc;
    if (!stall) begin
      unique case (sel)
        SEL_SEQ: pc_next = pc_seq;
        SEL_BR:  pc_next = pc_br;
        SEL_JMP: pc_next = jmp_tgt;
        SEL_RET: pc_next = ras_empty ? RST_V : ras_top;
        default: pc_next = pc_seq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RST_V;
    end else begin
      pc <= pc_next;
    end
  end

  pc_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_seq),
    .dout  (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl (AW=10, STEP=1, RESET_VEC=0, RAS_DEPTH=4).
module tb_pc_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, br_taken, jmp, call, ret;
  logic [AW-1:0] br_off, jmp_tgt;
  logic [AW-1:0] pc, pc_next;
  logic          ras_empty, ras_full, ras_ovf, ras_unf;

  int checks = 0;
  int errors = 0;

  pc_ctrl #(
    .AW        (AW),
    .STEP      (1),
    .RESET_VEC (0),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_off    (br_off),
    .jmp       (jmp),
    .call      (call),
    .jmp_tgt   (jmp_tgt),
    .ret       (ret),
    .pc        (pc),
    .pc_next   (pc_next),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic          stall, br, jmp, call, ret;
    logic [AW-1:0] off, tgt;
    logic [AW-1:0] epc;
    logic          eempty, efull, eovf, eunf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic b, input logic [AW-1:0] off,
                     input logic j, input logic c, input logic [AW-1:0] tgt,
                     input logic r, input logic [AW-1:0] epc,
                     input logic ee, input logic ef, input logic eo, input logic eu);
    vec_t v;
    v.stall = s; v.br = b; v.off = off; v.jmp = j; v.call = c; v.tgt = tgt; v.ret = r;
    v.epc = epc; v.eempty = ee; v.efull = ef; v.eovf = eo; v.eunf = eu;
    tbl.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    stall = 0; br_taken = 0; br_off = '0; jmp = 0; call = 0; jmp_tgt = '0; ret = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic ee, input logic ef,
                           input logic eo, input logic eu);
    chk({tag, " ras_empty"}, 32'(ras_empty), 32'(ee));
    chk({tag, " ras_full"},  32'(ras_full),  32'(ef));
    chk({tag, " ras_ovf"},   32'(ras_ovf),   32'(eo));
    chk({tag, " ras_unf"},   32'(ras_unf),   32'(eu));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clear_in();
    #12;
    chk("reset pc", 32'(pc), 32'd0);
    chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Free run with wrap from 1023 to 0.
    for (int i = 1; i <= 1024; i++) begin
      exp_q.push_back(AW'(i));
    end
    while (exp_q.size() > 0) begin
      logic [AW-1:0] e;
      e = exp_q.pop_front();
      tick();
      chk($sformatf("freerun pc@%0d", e), 32'(pc), 32'(e));
    end
    chk_flags("freerun", 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall with ret held: nothing moves, no underflow pulse.
    for (int i = 0; i < 5; i++) tick();
    chk("pre-stall pc", 32'(pc), 32'd5);
    stall = 1; ret = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall pc_next", 32'(pc_next), 32'd5);
      tick();
      chk("stall pc", 32'(pc), 32'd5);
      chk_flags("stall", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    clear_in();
    tick();
    chk("stall release pc", 32'(pc), 32'd6);

    // Table-driven sequence starting from pc=10 with an empty RAS.
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("pre-table pc", 32'(pc), 32'd10);

    //   s  b  off      j  c  tgt       r  epc        emp full ovf unf
    add(0, 1, 10'h3FC, 0, 0, 10'd0,   0, 10'd7,    1, 0, 0, 0);
    add(0, 1, 10'd5,   0, 0, 10'd0,   0, 10'd13,   1, 0, 0, 0);
    add(0, 0, 10'd0,   1, 0, 10'd20,  0, 10'd20,   1, 0, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd100, 0, 10'd100,  0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   0, 10'd101,  0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   0, 10'd102,  0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd21,   1, 0, 0, 0);
    add(0, 0, 10'd0,   1, 0, 10'd1,   0, 10'd1,    1, 0, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd11,  0, 10'd11,   0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd21,  0, 10'd21,   0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd31,  0, 10'd31,   0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd41,  0, 10'd41,   0, 1, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd51,  0, 10'd51,   0, 1, 1, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd42,   0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd32,   0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd22,   0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd12,   1, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd0,    1, 0, 0, 1);
    add(0, 0, 10'd0,   1, 0, 10'd49,  0, 10'd49,   1, 0, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd200, 0, 10'd200,  0, 0, 0, 0);
    add(0, 1, 10'd7,   0, 1, 10'd300, 1, 10'd50,   1, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   0, 10'd51,   1, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd0,    1, 0, 0, 1);
    add(1, 0, 10'd0,   0, 0, 10'd0,   1, 10'd0,    1, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   0, 10'd1,    1, 0, 0, 0);
    add(0, 0, 10'd0,   1, 0, 10'd1020,0, 10'd1020, 1, 0, 0, 0);
    add(0, 1, 10'd10,  0, 0, 10'd0,   0, 10'd7,    1, 0, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd1023,0, 10'd1023, 0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 1, 10'd3,   0, 10'd3,    0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd0,    0, 0, 0, 0);
    add(0, 0, 10'd0,   0, 0, 10'd0,   1, 10'd8,    1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].stall; br_taken = tbl[i].br; br_off = tbl[i].off;
      jmp = tbl[i].jmp; call = tbl[i].call; jmp_tgt = tbl[i].tgt; ret = tbl[i].ret;
      #1;
      chk($sformatf("vec%0d pc_next", i), 32'(pc_next), 32'(tbl[i].epc));
      tick();
      chk($sformatf("vec%0d pc", i), 32'(pc), 32'(tbl[i].epc));
      chk_flags($sformatf("vec%0d", i), tbl[i].eempty, tbl[i].efull, tbl[i].eovf, tbl[i].eunf);
    end
    clear_in();

    // Asynchronous reset between edges at pc=300 with two RAS entries.
    jmp = 1; jmp_tgt = 10'd298;
    tick();
    clear_in();
    call = 1; jmp_tgt = 10'd299;
    tick();
    jmp_tgt = 10'd300;
    tick();
    clear_in();
    chk("pre-async pc", 32'(pc), 32'd300);
    chk("pre-async ras_empty", 32'(ras_empty), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async pc", 32'(pc), 32'd0);
    chk_flags("async", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post-async pc", 32'(pc), 32'd1);
    ret = 1;
    #1;
    chk("post-async ret pc_next", 32'(pc_next), 32'd0);
    tick();
    clear_in();
    chk("post-async ret pc", 32'(pc), 32'd0);
    chk("post-async ras_unf", 32'(ras_unf), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
